// File: rtl/pixel_write_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pixel_write_arbiter: round-robin, lockable arbiter for the VGA write port.  |
// | Optional clipping of off-screen pixels: define PIXEL_ARB_CLIP_EN.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pixel_write_arbiter #(
  parameter int NREQ = 3,
  parameter int X_W  = 8,
  parameter int Y_W  = 7,
  parameter int C_W  = 3
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic                stall,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ-1:0]     lock,
  input  logic [NREQ*X_W-1:0] x_in,
  input  logic [NREQ*Y_W-1:0] y_in,
  input  logic [NREQ*C_W-1:0] colour_in,
  output logic [NREQ-1:0]     ack,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [C_W-1:0]      colour,
  output logic                plot,
  output logic [1:0]          owner,
  output logic                locked,
  output logic [15:0]         clip_cnt
);

  localparam int c_X_LIMIT = 160;
  localparam int c_Y_LIMIT = 120;

  typedef enum logic [0:0] {
    ST_OPEN = 1'b0,
    ST_HELD = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [1:0]     r_owner;
  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y;
  logic [C_W-1:0] r_colour;
  logic           r_plot;

  logic [NREQ-1:0] w_ack;
  logic            w_xfer;
  logic [1:0]      w_grant;
  logic            w_grant_lock;
  logic [X_W-1:0]  w_sel_x;
  logic [Y_W-1:0]  w_sel_y;
  logic [C_W-1:0]  w_sel_colour;
  logic            w_clip;

  // Grant decode: held owner only, else first requester after the last owner.
  always_comb begin
    int w_idx;
    w_ack        = '0;
    w_xfer       = 1'b0;
    w_grant      = r_owner;
    w_grant_lock = 1'b0;
    w_sel_x      = x_in[X_W-1:0];
    w_sel_y      = y_in[Y_W-1:0];
    w_sel_colour = colour_in[C_W-1:0];
    w_idx        = 0;
    if (resetn && !stall) begin
      if (r_state == ST_HELD) begin
        for (int i = 0; i < NREQ; i++) begin
          if (2'(i) == r_owner && req[i]) begin
            w_xfer  = 1'b1;
            w_grant = 2'(i);
          end
        end
      end else begin
        for (int k = 1; k <= NREQ; k++) begin
          w_idx = (int'(r_owner) + k) % NREQ;
          for (int i = 0; i < NREQ; i++) begin
            if (!w_xfer && i == w_idx && req[i]) begin
              w_xfer  = 1'b1;
              w_grant = 2'(i);
            end
          end
        end
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (w_xfer && 2'(i) == w_grant) begin
        w_ack[i]     = 1'b1;
        w_grant_lock = lock[i];
        w_sel_x      = x_in[i*X_W +: X_W];
        w_sel_y      = y_in[i*Y_W +: Y_W];
        w_sel_colour = colour_in[i*C_W +: C_W];
      end
    end
  end

  // In HELD only the owner can transfer, so its lock bit alone picks the state.
  always_comb begin
    w_state_next = r_state;
    if (w_xfer) begin
      w_state_next = w_grant_lock ? ST_HELD : ST_OPEN;
    end
  end

`ifdef PIXEL_ARB_CLIP_EN
  logic [15:0] r_clip_cnt;

  assign w_clip = w_xfer &&
                  ((int'(w_sel_x) >= c_X_LIMIT) || (int'(w_sel_y) >= c_Y_LIMIT));

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      r_clip_cnt <= '0;
    end else if (w_clip && r_clip_cnt != 16'hFFFF) begin
      r_clip_cnt <= r_clip_cnt + 16'd1;
    end
  end

  assign clip_cnt = r_clip_cnt;
`else
  assign w_clip   = 1'b0;
  assign clip_cnt = '0;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      r_state  <= ST_OPEN;
      r_owner  <= 2'(NREQ - 1);
      r_x      <= '0;
      r_y      <= '0;
      r_colour <= '0;
      r_plot   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_plot  <= 1'b0;
      if (w_xfer) begin
        r_owner <= w_grant;
        if (!w_clip) begin
          r_x      <= w_sel_x;
          r_y      <= w_sel_y;
          r_colour <= w_sel_colour;
          r_plot   <= 1'b1;
        end
      end
    end
  end

  assign ack    = w_ack;
  assign x      = r_x;
  assign y      = r_y;
  assign colour = r_colour;
  assign plot   = r_plot;
  assign owner  = r_owner;
  assign locked = (r_state == ST_HELD);

endmodule
`default_nettype wire

// File: tb/tb_pixel_write_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pixel_write_arbiter: table, directed and random checks against a model. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_pixel_write_arbiter;

  localparam int c_N = 3;
`ifdef PIXEL_ARB_CLIP_EN
  localparam bit c_CLIP = 1'b1;
`else
  localparam bit c_CLIP = 1'b0;
`endif

  logic            CLOCK_50 = 1'b0;
  logic            resetn;
  logic            stall;
  logic [2:0]      req;
  logic [2:0]      lock;
  logic [23:0]     x_in;
  logic [20:0]     y_in;
  logic [8:0]      colour_in;
  logic [2:0]      ack;
  logic [7:0]      x;
  logic [6:0]      y;
  logic [2:0]      colour;
  logic            plot;
  logic [1:0]      owner;
  logic            locked;
  logic [15:0]     clip_cnt;

  logic [7:0] tx [c_N];
  logic [6:0] ty [c_N];
  logic [2:0] tc [c_N];

  int n_chk  = 0;
  int n_fail = 0;
  logic [2:0] last_ack;

  // Reference state
  int         m_owner = 2;
  bit         m_locked = 0;
  logic [7:0] m_x = 0;
  logic [6:0] m_y = 0;
  logic [2:0] m_c = 0;
  bit         m_plot = 0;
  int         m_clip = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  always_comb begin
    x_in = '0; y_in = '0; colour_in = '0;
    for (int i = 0; i < c_N; i++) begin
      x_in[i*8 +: 8]      = tx[i];
      y_in[i*7 +: 7]      = ty[i];
      colour_in[i*3 +: 3] = tc[i];
    end
  end

  pixel_write_arbiter #(.NREQ(3), .X_W(8), .Y_W(7), .C_W(3)) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .stall(stall), .req(req), .lock(lock),
    .x_in(x_in), .y_in(y_in), .colour_in(colour_in), .ack(ack),
    .x(x), .y(y), .colour(colour), .plot(plot), .owner(owner),
    .locked(locked), .clip_cnt(clip_cnt)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] model_ack();
    int idx;
    if (!resetn || stall) return 3'b000;
    if (m_locked) return req[m_owner] ? (3'b001 << m_owner) : 3'b000;
    for (int k = 1; k <= c_N; k++) begin
      idx = (m_owner + k) % c_N;
      if (req[idx]) return 3'b001 << idx;
    end
    return 3'b000;
  endfunction

  // One clock: check ack mid-cycle, advance model at the edge, check outputs.
  task automatic step();
    logic [2:0] ea;
    int g;
    bit clipped;
    @(negedge CLOCK_50);
    ea = model_ack();
    last_ack = ack;
    chk("ack", int'(ack), int'(ea));
    @(posedge CLOCK_50);
    #1;
    if (!resetn) begin
      m_owner = c_N - 1; m_locked = 0; m_x = 0; m_y = 0; m_c = 0;
      m_plot = 0; m_clip = 0;
    end else if (ea != 0) begin
      g = (ea == 3'b001) ? 0 : (ea == 3'b010) ? 1 : 2;
      m_owner  = g;
      m_locked = lock[g];
      clipped  = c_CLIP && (tx[g] >= 160 || ty[g] >= 120);
      if (clipped) begin
        m_plot = 0;
        if (m_clip < 65535) m_clip++;
      end else begin
        m_plot = 1; m_x = tx[g]; m_y = ty[g]; m_c = tc[g];
      end
    end else begin
      m_plot = 0;
    end
    chk("x", int'(x), int'(m_x));
    chk("y", int'(y), int'(m_y));
    chk("colour", int'(colour), int'(m_c));
    chk("plot", int'(plot), int'(m_plot));
    chk("owner", int'(owner), m_owner);
    chk("locked", int'(locked), int'(m_locked));
    chk("clip_cnt", int'(clip_cnt), m_clip);
  endtask

  task automatic do_reset();
    resetn = 1'b0; req = 3'b111; lock = 3'b000; stall = 1'b0;
    step();
    resetn = 1'b1; req = 3'b000;
  endtask

  typedef struct {
    logic [2:0] req;
    logic [2:0] exp_ack;
  } vec_t;

  vec_t rr_tab [6];

  initial begin
    rr_tab[0] = '{3'b111, 3'b001};
    rr_tab[1] = '{3'b111, 3'b010};
    rr_tab[2] = '{3'b111, 3'b100};
    rr_tab[3] = '{3'b111, 3'b001};
    rr_tab[4] = '{3'b111, 3'b010};
    rr_tab[5] = '{3'b111, 3'b100};
    for (int i = 0; i < c_N; i++) begin
      tx[i] = 8'(10 + i); ty[i] = 7'(20 + i); tc[i] = 3'(i + 1);
    end

    // Reset with all requests high
    resetn = 1'b0; req = 3'b111; lock = 3'b000; stall = 1'b0;
    #1;
    chk("reset_ack", int'(ack), 0);
    step();
    chk("reset_plot", int'(plot), 0);
    chk("reset_x", int'(x), 0);
    chk("reset_owner", int'(owner), 2);
    resetn = 1'b1;

    // Round-robin table
    for (int i = 0; i < 6; i++) begin
      req = rr_tab[i].req;
      for (int j = 0; j < c_N; j++) tx[j] = 8'(i * 16 + j);
      step();
      chk("rr_ack", int'(last_ack), int'(rr_tab[i].exp_ack));
      chk("rr_x", int'(x), i * 16 + (i % 3));
      chk("rr_plot", int'(plot), 1);
    end

    // Lock burst from requester 0 with requester 2 waiting
    do_reset();
    req = 3'b101;
    for (int i = 0; i < 5; i++) begin
      lock = (i < 4) ? 3'b001 : 3'b000;
      tx[0] = 8'(40 + i);
      step();
      chk("burst_ack", int'(last_ack), 1);
      chk("burst_x", int'(x), 40 + i);
    end
    lock = 3'b000;
    req  = 3'b100;
    step();
    chk("burst_after", int'(last_ack), 4);

    // Stall
    req = 3'b010; stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("stall_ack", int'(last_ack), 0);
      chk("stall_plot", int'(plot), 0);
    end
    stall = 1'b0;
    step();
    chk("unstall_ack", int'(last_ack), 2);
    chk("unstall_plot", int'(plot), 1);

    // Clip corner
    do_reset();
    req = 3'b010; tx[1] = 8'd200; ty[1] = 7'd10;
    step();
    chk("clip1_ack", int'(last_ack), 2);
    chk("clip1_plot", int'(plot), c_CLIP ? 0 : 1);
    chk("clip1_cnt", int'(clip_cnt), c_CLIP ? 1 : 0);
    if (!c_CLIP) chk("clip1_x", int'(x), 200);
    tx[1] = 8'd5; ty[1] = 7'd5;
    step();
    chk("clip2_ack", int'(last_ack), 2);
    chk("clip2_plot", int'(plot), 1);
    chk("clip2_xy", int'({x, 1'b0, y}), int'({8'd5, 1'b0, 7'd5}));
    req = 3'b000;

    // Reset in the middle of a held burst
    do_reset();
    req = 3'b001; lock = 3'b001;
    step();
    chk("held", int'(locked), 1);
    resetn = 1'b0; req = 3'b111;
    step();
    chk("rst_locked", int'(locked), 0);
    chk("rst_owner", int'(owner), 2);
    resetn = 1'b1; lock = 3'b000;
    step();
    chk("rst_first", int'(last_ack), 1);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      resetn = ($urandom_range(0, 39) != 0);
      stall  = ($urandom_range(0, 7) == 0);
      req    = 3'($urandom_range(0, 7));
      lock   = 3'($urandom_range(0, 7));
      for (int i = 0; i < c_N; i++) begin
        tx[i] = 8'($urandom_range(0, 255));
        ty[i] = 7'($urandom_range(0, 127));
        tc[i] = 3'($urandom_range(0, 7));
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
